hollow_triangle_rasterizer: RTL and testbench

Outline (hollow) triangle rasterizer. Accepts three integer vertices and a colour on a start pulse, then walks the three edges v0→v1, v1→v2 and v2→v0 with Bresenham line stepping. It emits one pixel per cycle on a valid-qualified pixel stream. It sits between the shape-command front end and the framebuffer write port of the 2D shapes GPU.

---
 rtl/triangle_raster_pkg.sv | 18 +
 rtl/bresenham_line_stepper.sv | 72 +++++++
 rtl/hollow_triangle_rasterizer.sv | 143 ++++++++++++++
 tb/tb_hollow_triangle_rasterizer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/triangle_raster_pkg.sv
// rtl/triangle_raster_pkg.sv - shared types and defaults for the hollow triangle rasterizer
package triangle_raster_pkg;

  localparam int COORD_W_DEFAULT = 8;
  localparam int COLOR_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef logic [1:0] edge_idx_t;

  typedef logic signed [COORD_W_DEFAULT+1:0] err_t;

endpackage

// File: rtl/bresenham_line_stepper.sv
// rtl/bresenham_line_stepper.sv - single-edge Bresenham walker: load endpoints, step one pixel per cycle
module bresenham_line_stepper #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               at_end
);

  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  logic [COORD_W-1:0]   end_x, end_y;
  logic signed [EW-1:0] dx, dy, err;
  logic                 sx_neg, sy_neg;
  logic signed [EW-1:0] diff_x, diff_y, abs_x, abs_y, err_step;
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic                 step_x, step_y;

  always_comb begin
    diff_x   = $signed({2'b00, bx}) - $signed({2'b00, ax});
    diff_y   = $signed({2'b00, by}) - $signed({2'b00, ay});
    abs_x    = diff_x[EW-1] ? -diff_x : diff_x;
    abs_y    = diff_y[EW-1] ? -diff_y : diff_y;
    e2       = $signed({err, 1'b0});
    dx_ext   = $signed({dx[EW-1], dx});
    dy_ext   = $signed({dy[EW-1], dy});
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    // both moves are judged against the pre-step error term
    err_step = err + (step_x ? dy : '0) + (step_y ? dx : '0);
  end

  assign at_end = (cur_x == end_x) && (cur_y == end_y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x  <= '0;
      cur_y  <= '0;
      end_x  <= '0;
      end_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      cur_x  <= ax;
      cur_y  <= ay;
      end_x  <= bx;
      end_y  <= by;
      dx     <= abs_x;
      dy     <= -abs_y;
      err    <= abs_x - abs_y;
      sx_neg <= !(ax < bx);
      sy_neg <= !(ay < by);
    end else if (step) begin
      err <= err_step;
      if (step_x) cur_x <= sx_neg ? cur_x - ONE : cur_x + ONE;
      if (step_y) cur_y <= sy_neg ? cur_y - ONE : cur_y + ONE;
    end
  end

endmodule

// File: rtl/hollow_triangle_rasterizer.sv
// rtl/hollow_triangle_rasterizer.sv - outline triangle rasterizer walking v0->v1->v2->v0
// TRI_DEDUP_VERTEX_EN: suppress each edge's final pixel so every vertex is emitted once.
module hollow_triangle_rasterizer
  import triangle_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int COLOR_W = COLOR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic [COLOR_W-1:0] color,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               pixel_valid,
  output logic               done
);

  state_t             state, state_n;
  edge_idx_t          edge_idx, edge_idx_n;
  logic [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic [COLOR_W-1:0] color_r;
  logic [COORD_W-1:0] ax, ay, bx, by, cur_x, cur_y;
  logic               load, step, at_end, emit;

  always_comb begin
    ax = vx2; ay = vy2; bx = vx0; by = vy0;
    case (edge_idx)
      2'd0:    begin ax = vx0; ay = vy0; bx = vx1; by = vy1; end
      2'd1:    begin ax = vx1; ay = vy1; bx = vx2; by = vy2; end
      default: begin ax = vx2; ay = vy2; bx = vx0; by = vy0; end
    endcase
  end

  bresenham_line_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .ax     (ax),
    .ay     (ay),
    .bx     (bx),
    .by     (by),
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .at_end (at_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_idx <= '0;
    end else begin
      state    <= state_n;
      edge_idx <= edge_idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    edge_idx_n = edge_idx;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SETUP;
          edge_idx_n = '0;
        end
      end
      SETUP: begin
        load    = 1'b1;
        state_n = DRAW;
      end
      DRAW: begin
        if (at_end) begin
          if (edge_idx < 2'd2) begin
            edge_idx_n = edge_idx + 2'd1;
            state_n    = SETUP;
          end else begin
            state_n = FINISH;
          end
        end else begin
          step = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef TRI_DEDUP_VERTEX_EN
  assign emit = (state == DRAW) && !at_end;
`else
  assign emit = (state == DRAW);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vx0     <= '0;
      vy0     <= '0;
      vx1     <= '0;
      vy1     <= '0;
      vx2     <= '0;
      vy2     <= '0;
      color_r <= '0;
    end else if (state == IDLE && start) begin
      vx0     <= x0;
      vy0     <= y0;
      vx1     <= x1;
      vy1     <= y1;
      vx2     <= x2;
      vy2     <= y2;
      color_r <= color;
    end
  end

  // px/py/colour only move on emitted pixels so they hold through gaps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px          <= '0;
      py          <= '0;
      pixel_color <= '0;
      pixel_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      pixel_valid <= emit;
      done        <= (state == FINISH);
      if (emit) begin
        px          <= cur_x;
        py          <= cur_y;
        pixel_color <= color_r;
      end
    end
  end

endmodule

// File: tb/tb_hollow_triangle_rasterizer.sv
// tb/tb_hollow_triangle_rasterizer.sv - table-driven self-checking bench for hollow_triangle_rasterizer
module tb_hollow_triangle_rasterizer;

`ifdef TRI_DEDUP_VERTEX_EN
  localparam int DEDUP = 1;
`else
  localparam int DEDUP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [23:0] color = '0;
  logic [7:0]  px, py;
  logic [23:0] pixel_color;
  logic        pixel_valid, done;

  always #5 clk = ~clk;

  hollow_triangle_rasterizer #(.COORD_W(8), .COLOR_W(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .x2          (x2),
    .y2          (y2),
    .color       (color),
    .px          (px),
    .py          (py),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .done        (done)
  );

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int color;
    int pixels;
    int cycles;
    int fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;
  int   cap_x[$];
  int   cap_y[$];

  int ex_x[21] = '{1, 2, 3,  3, 4, 5, 6, 7, 8, 9, 10,  10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
  int ex_y[21] = '{7, 7, 7,  7, 7, 8, 8, 8, 8, 9, 9,   9, 9, 9, 8, 8, 8, 8, 7, 7, 7};
  bit ex_last[21] = '{0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_tri(input vec_t v, input string tag, input int restart_at);
    int cyc = 0, npix = 0, first = -1, done_cyc = -1, ndone = 0;
    int bad_step = 0, bad_col = 0, overlap = 0, dxs, dys;
    cap_x.delete();
    cap_y.delete();
    @(negedge clk);
    x0 = v.x0[7:0]; y0 = v.y0[7:0]; x1 = v.x1[7:0];
    y1 = v.y1[7:0]; x2 = v.x2[7:0]; y2 = v.y2[7:0];
    color = v.color[23:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x0 = 8'hAA; y0 = 8'h55; x1 = 8'h3C; y1 = 8'hC3; x2 = 8'h0F; y2 = 8'hF0;
    color = 24'h5A5A5A;
    while (cyc < v.cycles + 4) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == restart_at);
      if (pixel_valid) begin
        if (first < 0) first = cyc;
        if (npix > 0) begin
          dxs = int'(px) - cap_x[$];
          dys = int'(py) - cap_y[$];
          if (dxs > 1 || dxs < -1 || dys > 1 || dys < -1) bad_step++;
        end
        if (pixel_color !== v.color[23:0]) bad_col++;
        cap_x.push_back(int'(px));
        cap_y.push_back(int'(py));
        npix++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        if (pixel_valid) overlap++;
      end
    end
    start = 1'b0;
    chk({tag, "_pixels"}, npix, v.pixels);
    chk({tag, "_done_cycle"}, done_cyc, v.cycles);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_done_overlap"}, overlap, 0);
    chk({tag, "_color"}, bad_col, 0);
    chk({tag, "_adjacent"}, bad_step, 0);
    if (v.pixels > 0 && npix > 0) begin
      chk({tag, "_first_latency"}, first, 2);
      chk({tag, "_first_xy"}, cap_x[0] * 256 + cap_y[0], v.fx * 256 + v.fy);
      chk({tag, "_last_xy"}, cap_x[$] * 256 + cap_y[$], v.lx * 256 + v.ly);
      if (DEDUP == 0) chk({tag, "_last_to_done"}, done_cyc - (first + npix + 1), 1);
    end
  endtask

  task automatic check_example_stream(input string tag);
    int k = 0;
    for (int i = 0; i < 21; i++) begin
      if (DEDUP == 0 || !ex_last[i]) begin
        if (k < cap_x.size())
          chk($sformatf("%s_pix%0d", tag, k), cap_x[k] * 256 + cap_y[k], ex_x[i] * 256 + ex_y[i]);
        else
          chk($sformatf("%s_pix%0d_missing", tag, k), cap_x.size(), k + 1);
        k++;
      end
    end
  endtask

  task automatic check_extreme_diagonal();
    int base = (DEDUP != 0) ? 255 : 256;
    int len = (DEDUP != 0) ? 255 : 256;
    int bad = 0;
    for (int i = base + 1; i < base + len && i < cap_x.size(); i++) begin
      if (!(cap_x[i] == cap_x[i-1] - 1 && cap_y[i] == cap_y[i-1] + 1)) bad++;
    end
    chk("extreme_diag_monotonic", bad, 0);
    if (cap_x.size() > base) chk("extreme_diag_start", cap_x[base] * 256 + cap_y[base], 255 * 256 + 0);
  endtask

  initial begin
    int nd;
    vecs[0] = '{1, 7, 3, 7, 10, 9, 'hFF0000, (DEDUP != 0) ? 18 : 21, 25, 1, 7, (DEDUP != 0) ? 2 : 1, 7};
    vecs[1] = '{5, 5, 5, 5, 5, 5, 'h00FF00, (DEDUP != 0) ? 0 : 3, 7, 5, 5, 5, 5};
    vecs[2] = '{0, 0, 4, 2, 2, 6, 'h123456, (DEDUP != 0) ? 14 : 17, 21, 0, 0, 0, (DEDUP != 0) ? 1 : 0};
    vecs[3] = '{0, 0, 255, 0, 0, 255, 'h0000FF, (DEDUP != 0) ? 765 : 768, 772, 0, 0, 0, (DEDUP != 0) ? 1 : 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", pixel_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_px", px, 0);
    chk("reset_py", py, 0);
    chk("reset_color", pixel_color, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_tri(vecs[i], $sformatf("v%0d", i), -1);
      if (i == 0) check_example_stream("example");
      if (i == 3) check_extreme_diagonal();
    end

    run_tri(vecs[0], "restart_in_draw", 6);
    check_example_stream("restart_stream");
    run_tri(vecs[2], "after_restart", -1);

    @(negedge clk);
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd255; y1 = 8'd0; x2 = 8'd0; y2 = 8'd255;
    color = 24'h0000FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_abort_valid", pixel_valid, 1);
    rst = 1'b0;
    #1;
    chk("abort_valid", pixel_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_px", px, 0);
    chk("abort_py", py, 0);
    chk("abort_color", pixel_color, 0);
    nd = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || pixel_valid) nd++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || pixel_valid) nd++;
    end
    chk("abort_no_activity", nd, 0);
    run_tri(vecs[0], "after_abort", -1);
    check_example_stream("after_abort_stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
